idstage: RTL and testbench

IDSTAGE -- requirements
Module: idstage

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/regfile.sv | 31 +++
 rtl/idstage.sv | 82 ++++++++
 tb/tb_idstage.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction class encodings, R15 index, NOP word
// and the immediate-extension helper used by the decode stage.
package cpu_pkg;

  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_BR  = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  localparam logic [3:0]  R15 = 4'hF;
  localparam logic [31:0] NOP = 32'h0000_0000;

  // Rotation is done on a doubled word so a zero rotate needs no special case.
  function automatic logic [31:0] ext_imm(input logic [31:0] instr);
    logic [63:0] dbl;
    logic [5:0]  rot;
    ext_imm = '0;
    dbl     = {24'h0, instr[7:0], 24'h0, instr[7:0]};
    rot     = {1'b0, instr[11:8], 1'b0};
    case (op_e'(instr[27:26]))
      OP_DP:   ext_imm = 32'(dbl >> rot);
      OP_MEM:  ext_imm = {20'h0, instr[11:0]};
      OP_BR:   ext_imm = {{6{instr[23]}}, instr[23:0], 2'b00};
      default: ext_imm = '0;
    endcase
  endfunction

endpackage

// File: rtl/regfile.sv
// R0..R14 register file: one synchronous write port, two asynchronous read
// ports; index 15 reads return the supplied r15 value and writes are dropped.
module regfile
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  ra1,
  input  logic [3:0]  ra2,
  input  logic        we3,
  input  logic [3:0]  wa3,
  input  logic [31:0] wd3,
  input  logic [31:0] r15,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] rf [0:14];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) rf[i] <= '0;
    end else if (we3 && (wa3 != R15)) begin
      rf[wa3] <= wd3;
    end
  end

  assign rd1 = (ra1 == R15) ? r15 : rf[ra1];
  assign rd2 = (ra2 == R15) ? r15 : rf[ra2];

endmodule

// File: rtl/idstage.sv
// Decode stage: IF/ID pipeline register, field decode, immediate extension
// and register read. Define IDSTAGE_WB_BYPASS_EN to forward writeback data.
module idstage
  import cpu_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrf,
  input  logic [31:0] pcplus8,
  input  logic        stalld,
  input  logic        flushd,
  input  logic        regwritew,
  input  logic [3:0]  wa3w,
  input  logic [31:0] wd3w,
  output logic [31:0] instrd,
  output logic [31:0] pcplus8d,
  output logic        validd,
  output logic [3:0]  ra1d,
  output logic [3:0]  ra2d,
  output logic [3:0]  wa3d,
  output logic [31:0] rd1d,
  output logic [31:0] rd2d,
  output logic [31:0] extimmd,
  output logic [3:0]  condd,
  output logic [1:0]  opd,
  output logic [5:0]  functd
);

  logic [31:0] rf_rd1;
  logic [31:0] rf_rd2;

  // Flush outranks stall so a redirect is never swallowed by a held bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instrd   <= NOP_INSTR;
      pcplus8d <= '0;
      validd   <= 1'b0;
    end else if (flushd) begin
      instrd   <= NOP_INSTR;
      pcplus8d <= pcplus8;
      validd   <= 1'b0;
    end else if (!stalld) begin
      instrd   <= instrf;
      pcplus8d <= pcplus8;
      validd   <= 1'b1;
    end
  end

  assign condd   = instrd[31:28];
  assign opd     = instrd[27:26];
  assign functd  = instrd[25:20];
  assign ra1d    = instrd[19:16];
  assign wa3d    = instrd[15:12];
  assign ra2d    = (op_e'(opd) == OP_MEM) ? instrd[15:12] : instrd[3:0];
  assign extimmd = ext_imm(instrd);

  regfile u_regfile (
    .clk   (clk),
    .reset (reset),
    .ra1   (ra1d),
    .ra2   (ra2d),
    .we3   (regwritew),
    .wa3   (wa3w),
    .wd3   (wd3w),
    .r15   (pcplus8d),
    .rd1   (rf_rd1),
    .rd2   (rf_rd2)
  );

`ifdef IDSTAGE_WB_BYPASS_EN
  logic wb_live;
  assign wb_live = regwritew && (wa3w != R15);
  assign rd1d    = (wb_live && (wa3w == ra1d)) ? wd3w : rf_rd1;
  assign rd2d    = (wb_live && (wa3w == ra2d)) ? wd3w : rf_rd2;
`else
  assign rd1d = rf_rd1;
  assign rd2d = rf_rd2;
`endif

endmodule

// File: tb/tb_idstage.sv
// Self-checking bench for idstage: decode vector table plus directed
// sequences for register file, stall/flush, same-cycle write and reset.
module tb_idstage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instrf;
  logic [31:0] pcplus8;
  logic        stalld;
  logic        flushd;
  logic        regwritew;
  logic [3:0]  wa3w;
  logic [31:0] wd3w;
  logic [31:0] instrd;
  logic [31:0] pcplus8d;
  logic        validd;
  logic [3:0]  ra1d;
  logic [3:0]  ra2d;
  logic [3:0]  wa3d;
  logic [31:0] rd1d;
  logic [31:0] rd2d;
  logic [31:0] extimmd;
  logic [3:0]  condd;
  logic [1:0]  opd;
  logic [5:0]  functd;

  int checks   = 0;
  int failures = 0;

  // clock / reset
  always #5 clk = ~clk;

  idstage dut (
    .clk       (clk),
    .reset     (reset),
    .instrf    (instrf),
    .pcplus8   (pcplus8),
    .stalld    (stalld),
    .flushd    (flushd),
    .regwritew (regwritew),
    .wa3w      (wa3w),
    .wd3w      (wd3w),
    .instrd    (instrd),
    .pcplus8d  (pcplus8d),
    .validd    (validd),
    .ra1d      (ra1d),
    .ra2d      (ra2d),
    .wa3d      (wa3d),
    .rd1d      (rd1d),
    .rd2d      (rd2d),
    .extimmd   (extimmd),
    .condd     (condd),
    .opd       (opd),
    .functd    (functd)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc8;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [3:0]  wa3;
    logic [31:0] imm;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // driver: one rising edge, then settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] ins, input logic [31:0] pc8);
    instrf  = ins;
    pcplus8 = pc8;
    step();
  endtask

  task automatic write_reg(input logic [3:0] idx, input logic [31:0] val);
    regwritew = 1'b1;
    wa3w      = idx;
    wd3w      = val;
    step();
    regwritew = 1'b0;
    #1;
  endtask

  initial begin
    vecs[0] = '{32'hE2812005, 32'h0000_0010, 4'hE, 2'b00, 6'h28, 4'h1, 4'h5, 4'h2, 32'h0000_0005};
    vecs[1] = '{32'hE3A004FF, 32'h0000_0014, 4'hE, 2'b00, 6'h3A, 4'h0, 4'hF, 4'h0, 32'hFF00_0000};
    vecs[2] = '{32'hE3A00E3F, 32'h0000_0018, 4'hE, 2'b00, 6'h3A, 4'h0, 4'hF, 4'h0, 32'h0000_03F0};
    vecs[3] = '{32'hE5913008, 32'h0000_001C, 4'hE, 2'b01, 6'h19, 4'h1, 4'h3, 4'h3, 32'h0000_0008};
    vecs[4] = '{32'hEA000002, 32'h0000_0020, 4'hE, 2'b10, 6'h20, 4'h0, 4'h2, 4'h0, 32'h0000_0008};
    vecs[5] = '{32'hEAFFFFFE, 32'h0000_0024, 4'hE, 2'b10, 6'h2F, 4'hF, 4'hE, 4'hF, 32'hFFFF_FFF8};
    vecs[6] = '{32'h5C123456, 32'h0000_0028, 4'h5, 2'b11, 6'h01, 4'h2, 4'h6, 4'h3, 32'h0000_0000};

    reset     = 1'b1;
    instrf    = 32'hFFFF_FFFF;
    pcplus8   = 32'h0000_0008;
    stalld    = 1'b0;
    flushd    = 1'b0;
    regwritew = 1'b0;
    wa3w      = 4'h0;
    wd3w      = '0;

    // reset state
    step();
    chk("rst_instrd", instrd, 32'h0);
    chk("rst_pc8d", pcplus8d, 32'h0);
    chk("rst_validd", 32'(validd), 32'h0);
    chk("rst_rd1d", rd1d, 32'h0);
    chk("rst_imm", extimmd, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // decode table
    for (int i = 0; i < 7; i++) begin
      load(vecs[i].instr, vecs[i].pc8);
      chk($sformatf("v%0d_instrd", i), instrd, vecs[i].instr);
      chk($sformatf("v%0d_pc8d", i), pcplus8d, vecs[i].pc8);
      chk($sformatf("v%0d_validd", i), 32'(validd), 32'h1);
      chk($sformatf("v%0d_condd", i), 32'(condd), 32'(vecs[i].cond));
      chk($sformatf("v%0d_opd", i), 32'(opd), 32'(vecs[i].op));
      chk($sformatf("v%0d_functd", i), 32'(functd), 32'(vecs[i].funct));
      chk($sformatf("v%0d_ra1d", i), 32'(ra1d), 32'(vecs[i].ra1));
      chk($sformatf("v%0d_ra2d", i), 32'(ra2d), 32'(vecs[i].ra2));
      chk($sformatf("v%0d_wa3d", i), 32'(wa3d), 32'(vecs[i].wa3));
      chk($sformatf("v%0d_imm", i), extimmd, vecs[i].imm);
    end

    // register file: write R1, then decode an instruction reading R1/R5
    instrf = 32'h0;
    write_reg(4'h1, 32'h0000_ABCD);
    load(32'hE2812005, 32'h0000_0100);
    chk("rf_r1", rd1d, 32'h0000_ABCD);
    chk("rf_r5", rd2d, 32'h0);

    // R15 reads return pcplus8d; a write to index 15 is dropped
    load(32'hEAFFFFFE, 32'h0000_0108);
    chk("r15_rd1", rd1d, 32'h0000_0108);
    stalld = 1'b1;
    write_reg(4'hF, 32'hDEAD_BEEF);
    chk("r15_wr_rd1", rd1d, 32'h0000_0108);
    chk("r15_wr_r14", rd2d, 32'h0);
    stalld = 1'b0;

    // stall holds for two cycles
    load(32'hE5913008, 32'h0000_0200);
    stalld = 1'b1;
    for (int c = 0; c < 2; c++) begin
      load(32'h1111_1111, 32'h0000_0300 + 32'(c));
      chk($sformatf("stall%0d_instrd", c), instrd, 32'hE5913008);
      chk($sformatf("stall%0d_pc8d", c), pcplus8d, 32'h0000_0200);
      chk($sformatf("stall%0d_validd", c), 32'(validd), 32'h1);
    end
    // flush beats stall
    flushd = 1'b1;
    load(32'h2222_2222, 32'h0000_0400);
    chk("flush_instrd", instrd, 32'h0);
    chk("flush_validd", 32'(validd), 32'h0);
    chk("flush_pc8d", pcplus8d, 32'h0000_0400);
    flushd = 1'b0;
    stalld = 1'b0;

    // same-cycle write/read of R4
    write_reg(4'h4, 32'h1111_1111);
    load(32'hE2841000, 32'h0000_0500);
    chk("r4_old", rd1d, 32'h1111_1111);
    stalld    = 1'b1;
    regwritew = 1'b1;
    wa3w      = 4'h4;
    wd3w      = 32'h2222_2222;
    #1;
`ifdef IDSTAGE_WB_BYPASS_EN
    chk("r4_samecycle", rd1d, 32'h2222_2222);
`else
    chk("r4_samecycle", rd1d, 32'h1111_1111);
`endif
    step();
    regwritew = 1'b0;
    #1;
    chk("r4_next", rd1d, 32'h2222_2222);
    stalld = 1'b0;

    // asynchronous reset mid-stall with a pending write
    write_reg(4'h0, 32'h5A5A_5A5A);
    load(32'hE3A004FF, 32'h0000_0600);
    chk("r0_pre", rd1d, 32'h5A5A_5A5A);
    stalld    = 1'b1;
    regwritew = 1'b1;
    wa3w      = 4'h0;
    wd3w      = 32'h7777_7777;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_instrd", instrd, 32'h0);
    chk("arst_validd", 32'(validd), 32'h0);
    chk("arst_pc8d", pcplus8d, 32'h0);
    chk("arst_rd1d", rd1d, 32'h0);
    chk("arst_imm", extimmd, 32'h0);
    regwritew = 1'b0;
    step();
    regwritew = 1'b1;
    step();
    regwritew = 1'b0;
    #1;
    chk("arst_hold_rd1d", rd1d, 32'h0);
    chk("arst_hold_instrd", instrd, 32'h0);
    @(negedge clk);
    reset  = 1'b0;
    stalld = 1'b0;
    load(32'hE3A004FF, 32'h0000_0700);
    chk("post_rst_r0", rd1d, 32'h0);
    chk("post_rst_validd", 32'(validd), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
